serial_frame_tx: RTL and testbench

//  Serialiser stage feeding the byte-wide shift path: accepts a parallel byte on a valid/ready

---
 rtl/serial_pkg.sv | 16 +
 rtl/bit_timer.sv | 31 +++
 rtl/serial_frame_tx.sv | 153 +++++++++++++++
 tb/tb_serial_frame_tx.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame transmitter: state encoding and
// frame constants.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter: counts DIV enabled cycles per serial bit and flags the
// last cycle of each period with bit_end.
module bit_timer #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clear,
  input  logic run,
  output logic bit_end
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign bit_end = (cnt == CNT_W'(DIV - 1));

  // The wrap at bit_end keeps every period exactly DIV enabled cycles long.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && run) begin
      cnt <= bit_end ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Byte serialiser: start bit, 8 data bits (LSB- or MSB-first), optional even
// parity bit (define PARITY_EN), stop bit; one bit per DIV enabled clocks.
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       lsb_first,
  output logic       tx_out,
  output logic       busy,
  output logic       done
);

  state_t      state, state_next;
  logic [7:0]  shift_reg, shift_next;
  logic [2:0]  bit_cnt, bit_cnt_next;
  logic        lsb_sel, lsb_sel_next;
  logic        tx_out_next;
  logic        busy_next;
  logic        done_next;
  logic        accept;
  logic        bit_end;
  logic        cur_bit;
  logic [7:0]  shifted;
`ifdef PARITY_EN
  logic        parity, parity_next;
`endif

  assign tx_ready = (state == IDLE) && en;
  assign accept   = tx_valid && tx_ready;

  // Next data bit and the register after it has been consumed, zero fill.
  assign cur_bit = lsb_sel ? shift_reg[0] : shift_reg[7];
  assign shifted = lsb_sel ? {1'b0, shift_reg[7:1]} : {shift_reg[6:0], 1'b0};

  bit_timer #(
    .DIV(DIV)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .clear   (accept),
    .run     (state != IDLE),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      lsb_sel   <= 1'b0;
      tx_out    <= LINE_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_cnt   <= bit_cnt_next;
      lsb_sel   <= lsb_sel_next;
      tx_out    <= tx_out_next;
      busy      <= busy_next;
      done      <= done_next;
`ifdef PARITY_EN
      parity    <= parity_next;
`endif
    end
  end

  // With en low everything holds except done, which is only ever a one-cycle pulse.
  always_comb begin
    state_next   = state;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt;
    lsb_sel_next = lsb_sel;
    tx_out_next  = tx_out;
    done_next    = 1'b0;
`ifdef PARITY_EN
    parity_next  = parity;
`endif
    if (en) begin
      case (state)
        IDLE: begin
          if (tx_valid) begin
            state_next   = START;
            shift_next   = tx_data;
            lsb_sel_next = lsb_first;
            bit_cnt_next = '0;
            tx_out_next  = 1'b0;
`ifdef PARITY_EN
            parity_next  = ^tx_data;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state_next   = DATA;
            tx_out_next  = cur_bit;
            shift_next   = shifted;
            bit_cnt_next = '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef PARITY_EN
              state_next  = PARITY;
              tx_out_next = parity;
`else
              state_next  = STOP;
              tx_out_next = LINE_IDLE;
`endif
            end else begin
              tx_out_next  = cur_bit;
              shift_next   = shifted;
              bit_cnt_next = bit_cnt + 3'd1;
            end
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state_next  = STOP;
            tx_out_next = LINE_IDLE;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            state_next  = IDLE;
            tx_out_next = LINE_IDLE;
            done_next   = 1'b1;
          end
        end
        default: begin
          state_next  = IDLE;
          tx_out_next = LINE_IDLE;
        end
      endcase
    end
    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx at DIV=4: table of frames plus hand-written
// back-to-back, enable-stall and mid-frame reset sequences.
module tb_serial_frame_tx;

  localparam int DIV = 4;
`ifdef PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  typedef struct {
    logic [7:0] data;
    logic       lsb;
    logic [7:0] seq;
    logic       par;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       lsb_first = 1'b0;
  logic       tx_ready, tx_out, busy, done;

  int checks = 0;
  int errors = 0;

  vec_t vecs[8];

  serial_frame_tx #(.DIV(DIV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .lsb_first (lsb_first),
    .tx_out    (tx_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // seq holds the data bits in send order, leftmost sent first.
  function automatic logic [10:0] build_frame(input logic [7:0] seq, input logic par);
    logic [10:0] fr;
    fr = '1;
    fr[0] = 1'b0;
    for (int i = 0; i < 8; i++) fr[1+i] = seq[7-i];
`ifdef PARITY_EN
    fr[9] = par;
`else
    fr[9] = par | 1'b1;
`endif
    return fr;
  endfunction

  // Called at #1 after the accept edge; ends at #1 after the done edge.
  task automatic frame_body(input string name, input logic [10:0] fr,
                            input int stall_at, input int stall_len);
    for (int c = 0; c < NB * DIV; c++) begin
      check({name, " tx_out"}, tx_out, fr[c / DIV]);
      check({name, " busy"}, busy, 1'b1);
      check({name, " done_low"}, done, 1'b0);
      check({name, " ready_low"}, tx_ready, 1'b0);
      if (c == stall_at) begin
        en = 1'b0;
        #1;
        check({name, " ready_en0"}, tx_ready, 1'b0);
        for (int s = 0; s < stall_len; s++) begin
          @(posedge clk); #1;
          check({name, " held_tx_out"}, tx_out, fr[c / DIV]);
          check({name, " held_done"}, done, 1'b0);
          check({name, " held_ready"}, tx_ready, 1'b0);
        end
        en = 1'b1;
      end
      @(posedge clk); #1;
    end
    check({name, " done"}, done, 1'b1);
    check({name, " busy_done"}, busy, 1'b0);
    check({name, " stop_idle"}, tx_out, 1'b1);
    check({name, " ready_done"}, tx_ready, 1'b1);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic lsb);
    @(negedge clk);
    tx_data   = data;
    lsb_first = lsb;
    tx_valid  = 1'b1;
    #1;
    check("ready_idle", tx_ready, 1'b1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name);
    @(posedge clk); #1;
    check({name, " done_pulse_end"}, done, 1'b0);
    check({name, " idle_line"}, tx_out, 1'b1);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 8'b10100101, 1'b0};
    vecs[1] = '{8'hA5, 1'b0, 8'b10100101, 1'b0};
    vecs[2] = '{8'h01, 1'b1, 8'b10000000, 1'b1};
    vecs[3] = '{8'h01, 1'b0, 8'b00000001, 1'b1};
    vecs[4] = '{8'hC1, 1'b1, 8'b10000011, 1'b1};
    vecs[5] = '{8'hC1, 1'b0, 8'b11000001, 1'b1};
    vecs[6] = '{8'h07, 1'b1, 8'b11100000, 1'b1};
    vecs[7] = '{8'h03, 1'b0, 8'b00000011, 1'b0};

    #12;
    check("rst_tx_out", tx_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready_en0", tx_ready, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    en = 1'b1;
    #1;
    check("ready_after_rst", tx_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("idle_line", tx_out, 1'b1);

    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].data, vecs[v].lsb);
      frame_body($sformatf("vec%0d", v), build_frame(vecs[v].seq, vecs[v].par), -1, 0);
      checkOutput($sformatf("vec%0d", v));
    end

    // Back-to-back: valid held; data changed mid-frame must be ignored until done.
    @(negedge clk);
    tx_data = 8'h01; lsb_first = 1'b1; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'hFF;
    frame_body("b2b_first", build_frame(8'b10000000, 1'b1), -1, 0);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    frame_body("b2b_second", build_frame(8'b11111111, 1'b0), -1, 0);
    checkOutput("b2b");

    // Enable stall of 5 cycles inside DATA bit 3 (frame bit 4).
    applyStimulus(8'hA5, 1'b1);
    frame_body("stall", build_frame(8'b10100101, 1'b0), 4 * DIV + 1, 5);
    checkOutput("stall");

    // Asynchronous reset mid-DATA, then a clean frame.
    applyStimulus(8'h00, 1'b1);
    repeat (2 * DIV + 1) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_tx_out", tx_out, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_done", done, 1'b0);
    applyStimulus(8'hC1, 1'b0);
    frame_body("postrst", build_frame(8'b11000001, 1'b1), -1, 0);
    checkOutput("postrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
